// File: rtl/wb_slave_decoder_if.sv
// wb_slave_decoder_if: master-side and fanned-out slave-side Wishbone signals of the decoder.
interface wb_slave_decoder_if #(
    parameter int SLAVES_WIDTH  = 1,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    localparam int SLAVES_COUNT = 1 << SLAVES_WIDTH;
    logic                               mCycI;
    logic                               mStbI;
    logic                               mWeI;
    logic                               mAckO;
    logic [ADDRESS_WIDTH-1:0]           mAdrI;
    logic [DATA_WIDTH-1:0]              mDatI;
    logic [DATA_WIDTH-1:0]              mDatO;
    logic [SLAVES_COUNT-1:0]            sCycO;
    logic [SLAVES_COUNT-1:0]            sStbO;
    logic                               sWeO;
    logic [SLAVES_COUNT-1:0]            sAckI;
    logic [ADDRESS_WIDTH-1:0]           sAdrO;
    logic [DATA_WIDTH-1:0]              sDatO;
    logic [DATA_WIDTH*SLAVES_COUNT-1:0] sDatIPacked;
    logic                               timeoutO;

    modport slave (
        input  mCycI, mStbI, mWeI, mAdrI, mDatI, sAckI, sDatIPacked,
        output mAckO, mDatO, sCycO, sStbO, sWeO, sAdrO, sDatO, timeoutO
    );
    modport master (
        output mCycI, mStbI, mWeI, mAdrI, mDatI, sAckI, sDatIPacked,
        input  mAckO, mDatO, sCycO, sStbO, sWeO, sAdrO, sDatO, timeoutO
    );
endinterface

// File: rtl/wb_slave_decoder.sv
// wb_slave_decoder: routes one Wishbone-classic master to 2**SLAVES_WIDTH slaves by address field,
// with a watchdog that completes unacknowledged strobes with DEFAULT_DATA.
module wb_slave_decoder #(
    parameter int                    SLAVES_WIDTH     = 1,
    parameter int                    ADDRESS_WIDTH    = 32,
    parameter int                    DATA_WIDTH       = 32,
    parameter int                    SLAVE_SELECT_LSB = 28,
    parameter int                    TIMEOUT_CYCLES   = 15,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_DATA     = DATA_WIDTH'(32'hDEADBEEF)
) (
    input logic                clk,
    input logic                rst,
    wb_slave_decoder_if.slave  bus
);
    localparam int SLAVES_COUNT = 1 << SLAVES_WIDTH;
    localparam int CW           = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, TIMEOUT} state_t;

    state_t                  state_q, state_d;
    logic [SLAVES_WIDTH-1:0] sel_q, sel_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic [SLAVES_WIDTH-1:0] idx;
    logic                    match, sel_ack, active, tmo, stall;
    logic [SLAVES_COUNT-1:0] s_cyc, s_stb;

    assign idx     = bus.mAdrI[SLAVE_SELECT_LSB +: SLAVES_WIDTH];
    assign match   = idx == sel_q;
    assign sel_ack = bus.sAckI[sel_q];
    assign active  = state_q == ACTIVE;
    assign tmo     = state_q == TIMEOUT;
    assign stall   = active & bus.mStbI & match & ~sel_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // ACTIVE branches follow transition priority: cycle end, re-decode, ack, watchdog, stall, idle strobe
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.mCycI & bus.mStbI) begin
                state_d = ACTIVE;
                sel_d   = idx;
                cnt_d   = '0;
            end
            ACTIVE: if (!bus.mCycI) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (bus.mStbI & !match) begin
                sel_d = idx;
                cnt_d = '0;
            end else if (bus.mStbI & sel_ack) begin
                cnt_d = '0;
            end else if (stall && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                state_d = TIMEOUT;
            end else if (stall) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = '0;
            end
            TIMEOUT: begin
                state_d = bus.mCycI ? ACTIVE : IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_cyc        = '0;
        s_stb        = '0;
        s_cyc[sel_q] = active & bus.mCycI;
        s_stb[sel_q] = active & bus.mStbI & match;
    end

    assign bus.sCycO    = s_cyc;
    assign bus.sStbO    = s_stb;
    assign bus.mAckO    = (active & bus.mStbI & match & sel_ack) | tmo;
    assign bus.mDatO    = tmo ? DEFAULT_DATA
                        : active ? bus.sDatIPacked[int'(sel_q) * DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.timeoutO = tmo;
    assign bus.sWeO     = bus.mWeI;
    assign bus.sAdrO    = bus.mAdrI;
    assign bus.sDatO    = bus.mDatI;
endmodule
